word_loader: RTL and testbench
==============================

WORD_LOADER -- requirements
Module: word_loader

Interface
REQ-001 ADDR_WIDTH, 4, address width of the input-word SRAM.
REQ-002 DATA_WIDTH, 8, character width.
REQ-003 DELIM, 8'h20, word delimiter character.
REQ-004 blocker_clk  input  1  clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  upstream character valid.
REQ-007 in_char  input  DATA_WIDTH  upstream character.
REQ-008 in_ready  output  1  character accepted on a rising edge with in_valid && in_ready.
REQ-009 wr_en  output  1  write strobe to input-word SRAM.
REQ-010 wr_addr  output  ADDR_WIDTH  SRAM write address.
REQ-011 wr_data  output  DATA_WIDTH  SRAM write data.
REQ-012 word_valid  output  1  null-terminated word complete in SRAM; matcher may start.
REQ-013 word_ack  input  1  matcher has finished with the word.
REQ-014 word_len  output  ADDR_WIDTH  stored character count, terminator excluded.
REQ-015 trunc  output  1  current word was truncated.

Function
REQ-016 FSM states SHALL be IDLE, FILL, TERM, HOLD, DRAIN.
REQ-017 in_ready SHALL be 1 in IDLE, FILL, DRAIN and 0 in TERM, HOLD and while rst_n is low.
REQ-018 IDLE: accepted DELIM or 0x00 SHALL be discarded (no empty words); any other char written at address 0, count<=1, -> FILL.
REQ-019 FILL: accepted non-delimiter char SHALL be written at address count, count<=count+1.
REQ-020 FILL: accepted DELIM or 0x00 SHALL not be written; -> TERM.
REQ-021 FILL: acceptance making count = 2^ADDR_WIDTH-1 (15 chars, addr 0..14) SHALL set trunc<=1 and -> TERM.
REQ-022 TERM: lasts one cycle; SHALL write 0x00 at address count; -> HOLD.
REQ-023 Writes SHALL be registered: wr_en/wr_addr/wr_data valid for exactly one cycle, the cycle after the acceptance edge (or the TERM cycle); wr_en 0 otherwise.
REQ-024 word_valid SHALL rise the cycle after the terminator write and hold until word_ack is sampled high in HOLD.
REQ-025 word_len SHALL equal count while word_valid is 1 and stay stable during HOLD.
REQ-026 HOLD + word_ack: word_valid<=0, count<=0; -> DRAIN if trunc else IDLE; trunc cleared on leaving HOLD.
REQ-027 DRAIN: accepted chars SHALL be discarded without writes until a DELIM or 0x00 is accepted; -> IDLE.
REQ-028 word_ack outside HOLD SHALL be ignored.
REQ-029 count is ADDR_WIDTH bits and SHALL never wrap (max 15 by REQ-021).
REQ-030 Sustained in_valid=1 SHALL sustain one accepted char per cycle in IDLE/FILL/DRAIN.

Reset
REQ-031 Asserting rst_n SHALL immediately force state IDLE, count 0, wr_en 0, wr_addr 0, wr_data 0, word_valid 0, word_len 0, trunc 0, in_ready 0.
REQ-032 Reset mid-word SHALL abandon the word with no terminator write; first edge after release is in IDLE with in_ready 1.

Structure
REQ-033 State enum, NUL constant (8'h00) and default DELIM SHALL reside in the shared tensor_core package, reused by the matcher.
REQ-034 Single module, no sub-module; the address counter is inline.

Verification
REQ-035 Stream "cat " back-to-back -> writes (0,'c'),(1,'a'),(2,'t'),(3,0x00) on consecutive cycles; word_valid=1, word_len=3, trunc=0.
REQ-036 Stream "  dog " with leading spaces -> leading spaces discarded, 'd' at addr 0, word_len=3.
REQ-037 20 non-delimiter chars then DELIM -> addr 0..14 written, 0x00 at addr 15, trunc=1, word_len=15; after word_ack, chars 16-20 and DELIM drained with no writes.
REQ-038 in_valid held high during HOLD -> in_ready=0, no writes; word_ack pulse -> word_valid=0 next cycle, next char written at addr 0.
REQ-039 rst_n low after 2 chars in FILL -> all outputs zero immediately; post-release "hi " yields word_len=2 at addr 0..2.
REQ-040 in_valid toggling 1/0 every cycle over "ab " -> writes only on accepted cycles, same SRAM contents as back-to-back.

Source files
------------

// File: rtl/tensor_core_pkg.sv
// Shared definitions for the word loader and the matcher that consumes its words.
package tensor_core_pkg;

    localparam int unsigned STATE_W = 3;

    typedef logic [STATE_W-1:0] state_t;

    // Loader FSM encoding
    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_FILL  = 3'd1;
    localparam state_t ST_TERM  = 3'd2;
    localparam state_t ST_HOLD  = 3'd3;
    localparam state_t ST_DRAIN = 3'd4;

    // String terminator and default word delimiter
    localparam logic [7:0] NUL           = 8'h00;
    localparam logic [7:0] DELIM_DEFAULT = 8'h20;

endpackage

// File: rtl/word_loader.sv
// Splits a character stream into null-terminated words in a small SRAM and
// hands each word to a downstream matcher with a valid/ack handshake.
module word_loader
    import tensor_core_pkg::*;
#(
    parameter int unsigned             ADDR_WIDTH = 4,
    parameter int unsigned             DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0]   DELIM      = DATA_WIDTH'(DELIM_DEFAULT)
) (
    input  logic                   blocker_clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic [DATA_WIDTH-1:0]  in_char,
    output logic                   in_ready,
    output logic                   wr_en,
    output logic [ADDR_WIDTH-1:0]  wr_addr,
    output logic [DATA_WIDTH-1:0]  wr_data,
    output logic                   word_valid,
    input  logic                   word_ack,
    output logic [ADDR_WIDTH-1:0]  word_len,
    output logic                   trunc
);

    // Last storable character position; the terminator then lands on the top address
    localparam logic [ADDR_WIDTH-1:0] MAX_COUNT = {ADDR_WIDTH{1'b1}};

    state_t                  state_q,      state_d;
    logic [ADDR_WIDTH-1:0]   count_q,      count_d;
    logic                    in_ready_q,   in_ready_d;
    logic                    wr_en_q,      wr_en_d;
    logic [ADDR_WIDTH-1:0]   wr_addr_q,    wr_addr_d;
    logic [DATA_WIDTH-1:0]   wr_data_q,    wr_data_d;
    logic                    word_valid_q, word_valid_d;
    logic [ADDR_WIDTH-1:0]   word_len_q,   word_len_d;
    logic                    trunc_q,      trunc_d;

    logic                    accept;
    logic                    is_sep;
    logic [ADDR_WIDTH-1:0]   count_inc;

    assign accept    = in_valid && in_ready_q;
    assign is_sep    = (in_char == DELIM) || (in_char == DATA_WIDTH'(NUL));
    assign count_inc = count_q + ADDR_WIDTH'(1);

    // Next-state, SRAM write and handshake decode
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        word_valid_d = word_valid_q;
        word_len_d   = word_len_q;
        trunc_d      = trunc_q;

        case (state_q)
            ST_IDLE: begin
                // Separators here would only create empty words
                if (accept && !is_sep) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = '0;
                    wr_data_d = in_char;
                    count_d   = ADDR_WIDTH'(1);
                    state_d   = ST_FILL;
                end
            end
            ST_FILL: begin
                if (accept) begin
                    if (is_sep) begin
                        // Terminator goes out right behind the last character
                        wr_en_d   = 1'b1;
                        wr_addr_d = count_q;
                        wr_data_d = DATA_WIDTH'(NUL);
                        state_d   = ST_TERM;
                    end else begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = count_q;
                        wr_data_d = in_char;
                        count_d   = count_inc;
                        if (count_inc == MAX_COUNT) begin
                            trunc_d = 1'b1;
                            state_d = ST_TERM;
                        end
                    end
                end
            end
            ST_TERM: begin
                // A truncated word still needs its terminator; a delimited one already has it
                word_len_d = count_q;
                state_d    = ST_HOLD;
                if (trunc_q) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = count_q;
                    wr_data_d = DATA_WIDTH'(NUL);
                end else begin
                    word_valid_d = 1'b1;
                end
            end
            ST_HOLD: begin
                if (!word_valid_q) begin
                    word_valid_d = 1'b1;
                end else if (word_ack) begin
                    word_valid_d = 1'b0;
                    word_len_d   = '0;
                    count_d      = '0;
                    trunc_d      = 1'b0;
                    state_d      = trunc_q ? ST_DRAIN : ST_IDLE;
                end
            end
            ST_DRAIN: begin
                // Throw away the tail of an over-long word
                if (accept && is_sep) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        in_ready_d = (state_d == ST_IDLE) || (state_d == ST_FILL) || (state_d == ST_DRAIN);
    end

    // State and registered outputs
    always_ff @(posedge blocker_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            count_q      <= '0;
            in_ready_q   <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            word_valid_q <= 1'b0;
            word_len_q   <= '0;
            trunc_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            in_ready_q   <= in_ready_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            word_valid_q <= word_valid_d;
            word_len_q   <= word_len_d;
            trunc_q      <= trunc_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign word_valid = word_valid_q;
    assign word_len   = word_len_q;
    assign trunc      = trunc_q;

endmodule

// File: tb/tb_word_loader.sv
// Scoreboard bench for word_loader: a stream-level word parser predicts SRAM
// writes and completed words; a monitor compares them as the DUT emits them.
module tb_word_loader;

    logic       blocker_clk;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_char;
    logic       in_ready;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       word_valid;
    logic       word_ack;
    logic [3:0] word_len;
    logic       trunc;

    word_loader dut (
        .blocker_clk (blocker_clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_char     (in_char),
        .in_ready    (in_ready),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .word_valid  (word_valid),
        .word_ack    (word_ack),
        .word_len    (word_len),
        .trunc       (trunc)
    );

    initial blocker_clk = 1'b0;
    always #5 blocker_clk = ~blocker_clk;

    typedef struct packed { logic [3:0] addr; logic [7:0] data; } wr_t;
    typedef struct packed { logic [3:0] len;  logic trunc; }      word_t;

    wr_t        exp_wr[$];
    word_t      exp_word[$];
    logic [7:0] stim[$];
    int         wr_log[$];

    int n_checks = 0;
    int n_pass   = 0;
    int cycle    = 0;
    int cur_len  = 0;

    // Reference parser state: 0 = between words, 1 = inside a word, 2 = skipping a long word's tail
    int m_mode = 0;
    int m_len  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Word splitting rules applied to one accepted character
    task automatic model_accept(input logic [7:0] c);
        bit sep;
        sep = (c == 8'h20) || (c == 8'h00);
        case (m_mode)
            0: if (!sep) begin
                exp_wr.push_back('{addr: 4'd0, data: c});
                m_len  = 1;
                m_mode = 1;
            end
            1: if (sep) begin
                exp_wr.push_back('{addr: 4'(m_len), data: 8'h00});
                exp_word.push_back('{len: 4'(m_len), trunc: 1'b0});
                m_len  = 0;
                m_mode = 0;
            end else begin
                exp_wr.push_back('{addr: 4'(m_len), data: c});
                m_len = m_len + 1;
                if (m_len == 15) begin
                    exp_wr.push_back('{addr: 4'd15, data: 8'h00});
                    exp_word.push_back('{len: 4'd15, trunc: 1'b1});
                    m_len  = 0;
                    m_mode = 2;
                end
            end
            default: if (sep) m_mode = 0;
        endcase
    endtask

    // Monitor: every SRAM write and every new word is popped from the scoreboard
    logic wv_prev = 1'b0;
    always @(negedge blocker_clk) begin
        if (!rst_n) begin
            wv_prev = 1'b0;
        end else begin
            cycle++;
            if (wr_en) begin
                wr_t e;
                wr_log.push_back(cycle);
                chk("write_expected", 32'(exp_wr.size() > 0), 32'd1);
                if (exp_wr.size() > 0) begin
                    e = exp_wr.pop_front();
                    chk("write_addr_data", {20'd0, wr_addr, wr_data}, {20'd0, e.addr, e.data});
                end
            end
            if (word_valid && !wv_prev) begin
                word_t w;
                chk("word_expected", 32'(exp_word.size() > 0), 32'd1);
                if (exp_word.size() > 0) begin
                    w = exp_word.pop_front();
                    cur_len = int'(w.len);
                    chk("word_len_trunc", {27'd0, word_len, trunc}, {27'd0, w.len, w.trunc});
                end
            end
            wv_prev = word_valid;
        end
    end

    // Matcher stand-in: acks words after a random delay, sprinkles ignored acks elsewhere
    initial begin
        word_ack = 1'b0;
        forever begin
            @(negedge blocker_clk);
            if (!rst_n) begin
                word_ack = 1'b0;
            end else if (word_ack) begin
                word_ack = 1'b0;
            end else if (word_valid) begin
                repeat ($urandom_range(1, 4)) @(negedge blocker_clk);
                chk("hold_blocks_input", {30'd0, in_ready, wr_en}, 32'd0);
                chk("hold_len_stable", 32'(word_len), 32'(cur_len));
                word_ack = 1'b1;
                @(negedge blocker_clk);
                word_ack = 1'b0;
                chk("valid_drops_after_ack", 32'(word_valid), 32'd0);
            end else if (in_ready && $urandom_range(0, 7) == 0) begin
                word_ack = 1'b1;
            end
        end
    end

    task automatic load_str(input string s);
        stim.delete();
        for (int i = 0; i < s.len(); i++) stim.push_back(s[i]);
    endtask

    // Drive the queued characters; mode 0 back-to-back, 1 toggling valid, 2 random gaps
    task automatic send_stim(input int mode);
        bit         tog = 1'b1;
        bit         v, rdy, accepted;
        int         tries;
        logic [7:0] c;
        while (stim.size() > 0) begin
            c = stim[0];
            accepted = 1'b0;
            tries = 0;
            while (!accepted && tries < 100) begin
                @(negedge blocker_clk);
                case (mode)
                    0:       v = 1'b1;
                    1:       begin v = tog; tog = !tog; end
                    default: v = ($urandom_range(0, 2) != 0);
                endcase
                in_valid = v;
                in_char  = v ? c : 8'($urandom);
                rdy      = in_ready;
                @(posedge blocker_clk);
                if (v && rdy) begin
                    accepted = 1'b1;
                    model_accept(c);
                end
                tries++;
            end
            chk("char_accepted", 32'(accepted), 32'd1);
            void'(stim.pop_front());
        end
        @(negedge blocker_clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        bit done = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge blocker_clk);
            #1;
            done = (exp_wr.size() == 0) && (exp_word.size() == 0) && !word_valid && !word_ack;
        end
        chk(tag, 32'(done), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"},   32'(in_ready),   32'd0);
        chk({tag, "_wr_en"},      32'(wr_en),      32'd0);
        chk({tag, "_wr_addr"},    32'(wr_addr),    32'd0);
        chk({tag, "_wr_data"},    32'(wr_data),    32'd0);
        chk({tag, "_word_valid"}, 32'(word_valid), 32'd0);
        chk({tag, "_word_len"},   32'(word_len),   32'd0);
        chk({tag, "_trunc"},      32'(trunc),      32'd0);
    endtask

    initial begin
        rst_n    = 1'b1;
        in_valid = 1'b0;
        in_char  = 8'h00;
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("por");
        in_valid = 1'b1;
        in_char  = "q";
        #20 check_reset_outputs("por_clocked");
        in_valid = 1'b0;
        #4 rst_n = 1'b1;
        @(posedge blocker_clk);
        @(negedge blocker_clk);
        chk("ready_after_release", 32'(in_ready), 32'd1);

        // Back-to-back word: four writes on consecutive cycles
        wr_log.delete();
        load_str("cat ");
        send_stim(0);
        wait_idle("cat_done");
        chk("cat_write_count", 32'(wr_log.size()), 32'd4);
        if (wr_log.size() == 4)
            chk("cat_consecutive", 32'(wr_log[3] - wr_log[0]), 32'd3);

        load_str("  dog ");
        send_stim(0);
        wait_idle("dog_done");

        // Over-long word: truncated at 15 and tail drained
        stim.delete();
        for (int i = 0; i < 20; i++) stim.push_back(8'("a" + i));
        stim.push_back(8'h20);
        send_stim(0);
        wait_idle("trunc_done");

        // Second word arrives while the first is held
        load_str("ab cd ");
        send_stim(0);
        wait_idle("hold_done");

        wr_log.delete();
        load_str("ab ");
        send_stim(1);
        wait_idle("toggle_done");
        chk("toggle_write_count", 32'(wr_log.size()), 32'd3);

        // Reset in the middle of a word
        load_str("xy");
        send_stim(0);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("mid_reset");
        m_mode = 0;
        m_len  = 0;
        #20 rst_n = 1'b1;
        @(posedge blocker_clk);
        @(negedge blocker_clk);
        chk("ready_after_mid_reset", 32'(in_ready), 32'd1);
        load_str("hi ");
        send_stim(0);
        wait_idle("hi_done");

        // Random words with random separators, bytes and pacing
        for (int w = 0; w < 30; w++) begin
            int len;
            stim.delete();
            repeat ($urandom_range(0, 2)) stim.push_back($urandom_range(0, 1) ? 8'h20 : 8'h00);
            len = $urandom_range(1, 18);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 9) == 0) stim.push_back(8'($urandom_range(0, 255)));
                else                          stim.push_back(8'("a" + $urandom_range(0, 25)));
            end
            stim.push_back($urandom_range(0, 1) ? 8'h20 : 8'h00);
            send_stim(int'($urandom_range(0, 2)));
        end
        wait_idle("random_done");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
